// File: rtl/mac_result_drain_pkg.sv
// rtl/mac_result_drain_pkg.sv - shared types, sizes and requant helper for the MAC result drain
package mac_drain_pkg;

   typedef enum logic {IDLE, EMIT} ser_state_t;

   localparam int LANES  = 4;
   localparam int LANE_W = 2;
   localparam int TAG_W  = 3;

   // Round half up, arithmetic shift, optional ReLU, saturate to w signed bits.
   // 32-bit arithmetic leaves headroom for any ACC_W up to 30.
   function automatic logic signed [31:0] requant(input logic signed [31:0] acc,
                                                  input logic [3:0]         shift,
                                                  input logic               relu,
                                                  input int                 w);
      logic signed [31:0] v;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      v  = acc;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (shift != 4'd0)
         v = (v + (32'sd1 <<< (shift - 4'd1))) >>> shift;
      if (relu && (v < 0))
         v = 32'sd0;
      if (v > hi)
         v = hi;
      else if (v < lo)
         v = lo;
      return v;
   endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// rtl/mac_result_drain_if.sv - valid/ready byte stream carrying requantized elements and row index
interface mac_result_drain_if #(
   parameter int W = 8
);
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] out_data;
   logic [4:0]          out_idx;

   modport master (output out_valid, output out_data, output out_idx, input out_ready);
   modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/mac_result_drain_fifo.sv
// rtl/mac_result_drain_fifo.sv - synchronous tile FIFO; a push into a full FIFO succeeds only alongside a pop
module drain_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/mac_result_drain.sv
// rtl/mac_result_drain.sv - captures 2x2 MAC tiles, requantizes, buffers and serializes them as a tagged byte stream
module mac_result_drain
   import mac_drain_pkg::*;
#(
   parameter int W      = 8,
   parameter int ACC_W  = 16,
   parameter int N_MACS = 4,
   parameter int DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_MACS-1:0]       valid_in,
   input  logic signed [ACC_W-1:0] acc_in_0,
   input  logic signed [ACC_W-1:0] acc_in_1,
   input  logic signed [ACC_W-1:0] acc_in_2,
   input  logic signed [ACC_W-1:0] acc_in_3,
   input  logic [TAG_W-1:0]        tile_tag,
   input  logic [3:0]              cfg_shift,
   input  logic                    cfg_relu,
   input  logic                    err_clr,
   output logic                    overflow_err,
   output logic                    partial_err,
   output logic                    busy,
   mac_result_drain_if.master      stream
);
   localparam int ENTRY_W = TAG_W + LANES * W;

   logic signed [ACC_W-1:0] acc_arr [LANES];
   logic [LANES*W-1:0]      lanes_q;
   logic                    capture;
   logic                    partial;
   logic                    stage_valid;
   logic [ENTRY_W-1:0]      stage_data;
   logic [ENTRY_W-1:0]      head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    load;
   logic                    drop;
   ser_state_t              state;
   ser_state_t              state_n;
   logic [LANE_W-1:0]       lane;
   logic [LANE_W-1:0]       lane_n;
   logic [ENTRY_W-1:0]      out_reg;
   logic [W-1:0]            lane_data;

   assign acc_arr[0] = acc_in_0;
   assign acc_arr[1] = acc_in_1;
   assign acc_arr[2] = acc_in_2;
   assign acc_arr[3] = acc_in_3;

   assign capture = (valid_in == '1);
   assign partial = (valid_in != '0) && !capture;

   always_comb begin
      lanes_q = '0;
      for (int i = 0; i < LANES; i++)
         lanes_q[i*W +: W] = W'(requant(32'(acc_arr[i]), cfg_shift, cfg_relu, W));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_valid <= 1'b0;
         stage_data  <= '0;
      end else begin
         stage_valid <= capture;
         if (capture)
            stage_data <= {tile_tag, lanes_q};
      end
   end

   drain_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (stage_valid),
      .push_data (stage_data),
      .pop       (load),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A full FIFO still accepts the stage entry when the serializer pops in the same cycle.
   assign drop = stage_valid && fifo_full && !load;

   always_comb begin
      state_n = state;
      lane_n  = lane;
      load    = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               load    = 1'b1;
               state_n = EMIT;
               lane_n  = '0;
            end
         end
         EMIT: begin
            if (stream.out_ready) begin
               lane_n = lane + 2'd1;
               if (lane == 2'd3) begin
                  if (!fifo_empty)
                     load = 1'b1;
                  else
                     state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         lane    <= '0;
         out_reg <= '0;
      end else begin
         state <= state_n;
         lane  <= lane_n;
         if (load)
            out_reg <= head;
      end
   end

   always_comb begin
      lane_data = '0;
      for (int i = 0; i < LANES; i++)
         if (lane == LANE_W'(i))
            lane_data = out_reg[i*W +: W];
   end

   assign stream.out_valid = (state == EMIT);
   assign stream.out_data  = lane_data;
   assign stream.out_idx   = {out_reg[ENTRY_W-1 -: TAG_W], lane};

   // Set beats clear when both happen in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_err <= 1'b0;
         partial_err  <= 1'b0;
      end else begin
         if (drop)
            overflow_err <= 1'b1;
         else if (err_clr)
            overflow_err <= 1'b0;
         if (partial)
            partial_err <= 1'b1;
         else if (err_clr)
            partial_err <= 1'b0;
      end
   end

   assign busy = stage_valid || !fifo_empty || (state != IDLE);
endmodule

// File: tb/tb_mac_result_drain.sv
// tb/tb_mac_result_drain.sv - directed self-checking bench for mac_result_drain
module tb_mac_result_drain;
   localparam int W     = 8;
   localparam int ACC_W = 16;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [3:0]              valid_in = '0;
   logic signed [ACC_W-1:0] acc_in_0 = '0;
   logic signed [ACC_W-1:0] acc_in_1 = '0;
   logic signed [ACC_W-1:0] acc_in_2 = '0;
   logic signed [ACC_W-1:0] acc_in_3 = '0;
   logic [2:0]              tile_tag = '0;
   logic [3:0]              cfg_shift = '0;
   logic                    cfg_relu = 1'b0;
   logic                    err_clr = 1'b0;
   logic                    overflow_err;
   logic                    partial_err;
   logic                    busy;

   mac_result_drain_if #(.W(W)) stream ();

   mac_result_drain #(.W(W), .ACC_W(ACC_W), .N_MACS(4), .DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .acc_in_0     (acc_in_0),
      .acc_in_1     (acc_in_1),
      .acc_in_2     (acc_in_2),
      .acc_in_3     (acc_in_3),
      .tile_tag     (tile_tag),
      .cfg_shift    (cfg_shift),
      .cfg_relu     (cfg_relu),
      .err_clr      (err_clr),
      .overflow_err (overflow_err),
      .partial_err  (partial_err),
      .busy         (busy),
      .stream       (stream)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int data;
   } elem_t;

   elem_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Round half up means floor(x + 0.5); then ReLU, then clamp to the signed W range.
   function automatic int model_requant(input int a, input int sh, input bit relu);
      int v;
      v = int'($floor(real'(a) / real'(1 << sh) + 0.5));
      if (relu && v < 0) v = 0;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      return v;
   endfunction

   task automatic push_exp(input int idx, input int data);
      elem_t e;
      e.idx  = idx;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; holds valid_in high across exactly one edge.
   task automatic capture(input int a0, input int a1, input int a2, input int a3,
                          input int tag, input int sh, input bit relu, input bit keep);
      acc_in_0  = ACC_W'(a0);
      acc_in_1  = ACC_W'(a1);
      acc_in_2  = ACC_W'(a2);
      acc_in_3  = ACC_W'(a3);
      tile_tag  = 3'(tag);
      cfg_shift = 4'(sh);
      cfg_relu  = relu;
      valid_in  = 4'b1111;
      if (keep) begin
         push_exp(tag * 4 + 0, model_requant(a0, sh, relu));
         push_exp(tag * 4 + 1, model_requant(a1, sh, relu));
         push_exp(tag * 4 + 2, model_requant(a2, sh, relu));
         push_exp(tag * 4 + 3, model_requant(a3, sh, relu));
      end
      step(1);
      valid_in = 4'b0000;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < budget) begin
         step(1);
         t++;
      end
      check(name, int'(exp_q.size() == 0 && !busy), 1);
   endtask

   logic prev_stall = 1'b0;
   int   prev_data;
   int   prev_idx;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (stream.out_valid) begin
            check("valid_with_expected_data", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               check("out_idx", int'(stream.out_idx), exp_q[0].idx);
               check("out_data", int'($signed(stream.out_data)), exp_q[0].data);
               if (stream.out_ready) void'(exp_q.pop_front());
            end
         end
         if (prev_stall) begin
            check("hold_valid", int'(stream.out_valid), 1);
            check("hold_data", int'($signed(stream.out_data)), prev_data);
            check("hold_idx", int'(stream.out_idx), prev_idx);
         end
         prev_stall = stream.out_valid && !stream.out_ready;
         prev_data  = int'($signed(stream.out_data));
         prev_idx   = int'(stream.out_idx);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int cnt;
      stream.out_ready = 1'b0;
      step(2);
      check("rst_out_valid", int'(stream.out_valid), 0);
      check("rst_out_data", int'(stream.out_data), 0);
      check("rst_out_idx", int'(stream.out_idx), 0);
      check("rst_overflow_err", int'(overflow_err), 0);
      check("rst_partial_err", int'(partial_err), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      step(1);

      // Single tile, literal expectations and first-valid latency
      stream.out_ready = 1'b1;
      push_exp(4, 25); push_exp(5, -25); push_exp(6, 75); push_exp(7, -1);
      capture(100, -100, 300, -5, 1, 2, 1'b0, 1'b0);
      @(negedge clk);
      check("latency_after_k", int'(stream.out_valid), 0);
      step(1);
      @(negedge clk);
      check("latency_after_k1", int'(stream.out_valid), 0);
      step(1);
      @(negedge clk);
      check("latency_after_k2", int'(stream.out_valid), 1);
      step(1);
      wait_drain("single_drain", 40);

      // Saturation, ReLU, rounding
      push_exp(8, 127); push_exp(9, -128); push_exp(10, -1); push_exp(11, 2);
      capture(32767, -32768, -1, 2, 2, 0, 1'b0, 1'b0);
      wait_drain("sat_drain", 40);
      push_exp(12, 127); push_exp(13, 0); push_exp(14, 0); push_exp(15, 2);
      capture(32767, -32768, -1, 2, 3, 0, 1'b1, 1'b0);
      wait_drain("relu_drain", 40);
      push_exp(16, 2); push_exp(17, 1); push_exp(18, -1); push_exp(19, 0);
      capture(6, 5, -6, 0, 4, 2, 1'b0, 1'b0);
      wait_drain("round_drain", 40);

      // Stall mid-tile for 10 cycles
      capture(1000, -2000, -37, 77, 5, 3, 1'b0, 1'b1);
      t = 0;
      while (exp_q.size() != 3 && t < 20) begin
         step(1);
         t++;
      end
      check("bp_first_handshake", int'(exp_q.size()), 3);
      stream.out_ready = 1'b0;
      step(10);
      check("bp_nothing_lost", int'(exp_q.size()), 3);
      stream.out_ready = 1'b1;
      wait_drain("bp_drain", 40);

      // Overflow: 6 back-to-back captures with the sink stalled
      stream.out_ready = 1'b0;
      for (int i = 0; i < 6; i++)
         capture(i * 700 - 1500, 3000 - i * 900, -i * 40, i * 333, i, 4, 1'b1, i < 5);
      step(1);
      check("ovf_set", int'(overflow_err), 1);
      check("ovf_busy", int'(busy), 1);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("ovf_cleared", int'(overflow_err), 0);
      stream.out_ready = 1'b1;
      wait_drain("ovf_drain", 150);

      // Partial valid, with err_clr in the same cycle: set wins
      valid_in = 4'b0101;
      err_clr  = 1'b1;
      step(1);
      valid_in = 4'b0000;
      check("partial_set_wins", int'(partial_err), 1);
      step(1);
      check("partial_cleared", int'(partial_err), 0);
      err_clr = 1'b0;
      step(3);
      check("partial_no_output", int'(busy), 0);

      // Back-to-back: 12 contiguous valid beats
      capture(10, 20, 30, 40, 5, 0, 1'b0, 1'b1);
      capture(-10, -20, -30, -40, 6, 1, 1'b0, 1'b1);
      capture(255, -255, 129, -129, 7, 1, 1'b1, 1'b1);
      t = 0;
      @(negedge clk);
      while (!stream.out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("b2b_started", int'(stream.out_valid), 1);
      cnt = 0;
      while (stream.out_valid && cnt < 30) begin
         cnt++;
         @(negedge clk);
      end
      check("b2b_contiguous", cnt, 12);
      step(1);
      wait_drain("b2b_drain", 20);

      // Reset mid-EMIT with a second tile buffered
      stream.out_ready = 1'b0;
      capture(1, 2, 3, 4, 1, 0, 1'b0, 1'b1);
      capture(5, 6, 7, 8, 2, 0, 1'b0, 1'b1);
      t = 0;
      while (!stream.out_valid && t < 20) begin
         step(1);
         t++;
      end
      check("rst_test_emitting", int'(stream.out_valid), 1);
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("rst_mid_out_valid", int'(stream.out_valid), 0);
      check("rst_mid_busy", int'(busy), 0);
      step(1);
      rst = 1'b0;
      stream.out_ready = 1'b1;
      step(6);
      check("rst_fifo_empty", int'(busy), 0);
      check("rst_no_output", int'(stream.out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
